data_stack_ctrl: RTL and testbench

// - Forth data-stack controller sequencing the dual-port data memory (16b words, 1-cycle registered read).
// - Caches TOS and NOS in registers; deeper entries spill to / refill from a RAM window at STACK_BASE.
// - Sits between the core's decode/ALU and the data memory; the parent ties both memory clocks to clock.

---
 rtl/stack_pkg.sv | 21 ++
 rtl/data_stack_ctrl.sv | 129 ++++++++++++
 tb/tb_data_stack_ctrl.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_pkg.sv
// Shared definitions for the Forth data-stack controller: command encodings,
// controller states and the depth-counter width helper.
package stack_pkg;

    localparam logic [1:0] OP_PUSH    = 2'd0;
    localparam logic [1:0] OP_POP     = 2'd1;
    localparam logic [1:0] OP_REPLACE = 2'd2;
    localparam logic [1:0] OP_BINOP   = 2'd3;

    typedef enum logic [1:0] {
        IDLE,
        RD1,
        RD2
    } state_t;

    // Depth must be able to hold STACK_DEPTH itself, hence the extra bit.
    function automatic int depth_width(input int stack_depth);
        return $clog2(stack_depth) + 1;
    endfunction

endpackage

// File: rtl/data_stack_ctrl.sv
// Forth data-stack controller: TOS/NOS live in registers, deeper entries spill to
// and refill from a RAM window at STACK_BASE through a 1-cycle registered-read memory.
module data_stack_ctrl
    import stack_pkg::*;
#(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    ADDR_WIDTH  = 16,
    parameter logic [ADDR_WIDTH-1:0] STACK_BASE  = 'hFF00,
    parameter int                    STACK_DEPTH = 256,
    localparam int                   DW_D        = depth_width(STACK_DEPTH)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [DATA_WIDTH-1:0] cmd_data,
    output logic [DATA_WIDTH-1:0] tos,
    output logic [DATA_WIDTH-1:0] nos,
    output logic [DW_D-1:0]       depth,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  err_clear,
    output logic [DATA_WIDTH-1:0] mem_data,
    output logic [ADDR_WIDTH-1:0] mem_write_addr,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_read_addr,
    input  logic [DATA_WIDTH-1:0] mem_q
);

    localparam logic [DW_D-1:0] FULL = DW_D'(STACK_DEPTH);

    state_t                state;
    logic                  fire;
    logic                  has1;
    logic                  has2;
    logic                  has3;
    logic                  full;
    logic                  ovf_set;
    logic                  unf_set;
    logic                  shrink;
    logic [ADDR_WIDTH-1:0] spill_addr;
    logic [ADDR_WIDTH-1:0] refill_addr;

    assign cmd_ready = (state == IDLE);
    assign fire      = cmd_valid && cmd_ready;

    // Spill slot for the entry leaving NOS, and refill slot for the entry
    // that becomes NOS after the stack shrinks by one.
    always_comb begin
        has1        = (depth != '0);
        has2        = (depth >= DW_D'(2));
        has3        = (depth >= DW_D'(3));
        full        = (depth == FULL);
        ovf_set     = fire && (cmd_op == OP_PUSH) && full;
        unf_set     = fire && ((((cmd_op == OP_POP) || (cmd_op == OP_REPLACE)) && !has1) ||
                               ((cmd_op == OP_BINOP) && !has2));
        shrink      = fire && (((cmd_op == OP_POP) && has1) || ((cmd_op == OP_BINOP) && has2));
        spill_addr  = STACK_BASE + ADDR_WIDTH'(depth - DW_D'(2));
        refill_addr = STACK_BASE + ADDR_WIDTH'(depth - DW_D'(3));
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            tos            <= '0;
            nos            <= '0;
            depth          <= '0;
            overflow       <= 1'b0;
            underflow      <= 1'b0;
            mem_data       <= '0;
            mem_write_addr <= '0;
            mem_we         <= 1'b0;
            mem_read_addr  <= '0;
        end else begin
            mem_we <= 1'b0;
            // A fresh error in the same cycle as err_clear must survive.
            if (err_clear) begin
                overflow  <= 1'b0;
                underflow <= 1'b0;
            end
            if (ovf_set) overflow  <= 1'b1;
            if (unf_set) underflow <= 1'b1;

            case (state)
                IDLE: begin
                    if (fire) begin
                        case (cmd_op)
                            OP_PUSH: begin
                                if (!full) begin
                                    if (has2) begin
                                        mem_we         <= 1'b1;
                                        mem_write_addr <= spill_addr;
                                        mem_data       <= nos;
                                    end
                                    nos   <= tos;
                                    tos   <= cmd_data;
                                    depth <= depth + DW_D'(1);
                                end
                            end
                            OP_REPLACE: begin
                                if (has1) tos <= cmd_data;
                            end
                            default: begin
                                if (shrink) begin
                                    tos   <= (cmd_op == OP_POP) ? nos : cmd_data;
                                    depth <= depth - DW_D'(1);
                                    if (has3) begin
                                        mem_read_addr <= refill_addr;
                                        state         <= RD1;
                                    end else begin
                                        nos <= '0;
                                    end
                                end
                            end
                        endcase
                    end
                end
                RD1: state <= RD2;
                RD2: begin
                    nos   <= mem_q;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_stack_ctrl.sv
// Directed, table-driven bench for data_stack_ctrl with a behavioural
// dual-port RAM (registered read) standing in for the data memory.
module tb_data_stack_ctrl;
    import stack_pkg::*;

    logic        clock = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_data;
    logic [15:0] tos;
    logic [15:0] nos;
    logic [8:0]  depth;
    logic        overflow;
    logic        underflow;
    logic        err_clear;
    logic [15:0] mem_data;
    logic [15:0] mem_write_addr;
    logic        mem_we;
    logic [15:0] mem_read_addr;
    logic [15:0] mem_q;

    logic [15:0] ram [0:65535];
    int          we_total = 0;
    logic [15:0] last_waddr;
    logic [15:0] last_wdata;

    int n_vectors     = 0;
    int n_miscompares = 0;

    typedef struct {
        logic        valid;
        logic [1:0]  op;
        logic [15:0] data;
        logic        clr;
        logic [15:0] tos;
        logic [15:0] nos;
        logic [8:0]  depth;
        logic        ovf;
        logic        unf;
        int          busy;
        int          we;
        logic [15:0] waddr;
        logic [15:0] wdata;
        logic [15:0] raddr;
    } vec_t;

    localparam int NVEC = 22;
    vec_t vecs [NVEC];

    always #5 clock = ~clock;

    data_stack_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_data       (cmd_data),
        .tos            (tos),
        .nos            (nos),
        .depth          (depth),
        .overflow       (overflow),
        .underflow      (underflow),
        .err_clear      (err_clear),
        .mem_data       (mem_data),
        .mem_write_addr (mem_write_addr),
        .mem_we         (mem_we),
        .mem_read_addr  (mem_read_addr),
        .mem_q          (mem_q)
    );

    // Data memory model: write-enable port plus a registered read port.
    always @(posedge clock) begin
        if (mem_we) ram[mem_write_addr] <= mem_data;
        mem_q <= ram[mem_read_addr];
    end

    always @(negedge clock) begin
        if (mem_we === 1'b1) begin
            we_total   = we_total + 1;
            last_waddr = mem_write_addr;
            last_wdata = mem_data;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        n_vectors = n_vectors + 1;
        if (actual !== expected) begin
            n_miscompares = n_miscompares + 1;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        cmd_valid = 1'b0;
        err_clear = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        #1;
    endtask

    // Called at negedge+1; returns at negedge+1 once the controller is idle again.
    task automatic apply_stimulus(input logic valid, input logic [1:0] op,
                                  input logic [15:0] data, input logic clr,
                                  output int busy);
        int guard;
        guard = 0;
        busy  = 0;
        while (!cmd_ready && guard < 20) begin
            @(negedge clock);
            #1 guard++;
        end
        check_output("cmd_ready before command", 32'(cmd_ready), 32'd1);
        cmd_valid = valid;
        cmd_op    = op;
        cmd_data  = data;
        err_clear = clr;
        @(posedge clock);
        #1;
        cmd_valid = 1'b0;
        err_clear = 1'b0;
        @(negedge clock);
        #1;
        while (!cmd_ready && busy < 10) begin
            busy++;
            @(negedge clock);
            #1;
        end
    endtask

    function automatic vec_t mk(input logic valid, input logic [1:0] op, input logic [15:0] data,
                                input logic clr, input logic [15:0] t, input logic [15:0] n,
                                input logic [8:0] d, input logic ovf, input logic unf,
                                input int busy, input int we, input logic [15:0] waddr,
                                input logic [15:0] wdata, input logic [15:0] raddr);
        vec_t v;
        v.valid = valid; v.op = op; v.data = data; v.clr = clr;
        v.tos = t; v.nos = n; v.depth = d; v.ovf = ovf; v.unf = unf;
        v.busy = busy; v.we = we; v.waddr = waddr; v.wdata = wdata; v.raddr = raddr;
        return v;
    endfunction

    initial begin
        int busy;
        int w0;

        cmd_op   = OP_PUSH;
        cmd_data = '0;
        do_reset();

        check_output("reset tos",       32'(tos),            32'h0);
        check_output("reset nos",       32'(nos),            32'h0);
        check_output("reset depth",     32'(depth),          32'h0);
        check_output("reset overflow",  32'(overflow),       32'h0);
        check_output("reset underflow", 32'(underflow),      32'h0);
        check_output("reset mem_we",    32'(mem_we),         32'h0);
        check_output("reset waddr",     32'(mem_write_addr), 32'h0);
        check_output("reset raddr",     32'(mem_read_addr),  32'h0);
        check_output("reset mem_data",  32'(mem_data),       32'h0);
        check_output("reset cmd_ready", 32'(cmd_ready),      32'h1);

        //                valid op          data     clr   tos      nos      dep ovf unf busy we waddr    wdata    raddr
        vecs[0]  = mk(1, OP_PUSH,    16'h1111, 0, 16'h1111, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        vecs[1]  = mk(1, OP_PUSH,    16'h2222, 0, 16'h2222, 16'h1111, 2, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        vecs[2]  = mk(1, OP_PUSH,    16'h3333, 0, 16'h3333, 16'h2222, 3, 0, 0, 0, 1, 16'hFF00, 16'h1111, 16'h0000);
        vecs[3]  = mk(1, OP_POP,     16'h0000, 0, 16'h2222, 16'h1111, 2, 0, 0, 2, 0, 16'h0000, 16'h0000, 16'hFF00);
        vecs[4]  = mk(1, OP_REPLACE, 16'h00AA, 0, 16'h00AA, 16'h1111, 2, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        vecs[5]  = mk(1, OP_BINOP,   16'h0007, 0, 16'h0007, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        vecs[6]  = mk(1, OP_BINOP,   16'h0009, 0, 16'h0007, 16'h0000, 1, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        vecs[7]  = mk(1, OP_POP,     16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        vecs[8]  = mk(1, OP_POP,     16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        vecs[9]  = mk(0, OP_PUSH,    16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        vecs[10] = mk(1, OP_REPLACE, 16'h5555, 0, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        vecs[11] = mk(1, OP_POP,     16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        vecs[12] = mk(0, OP_PUSH,    16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        vecs[13] = mk(1, OP_PUSH,    16'h0001, 0, 16'h0001, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        vecs[14] = mk(1, OP_PUSH,    16'h0002, 0, 16'h0002, 16'h0001, 2, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
        vecs[15] = mk(1, OP_PUSH,    16'h0003, 0, 16'h0003, 16'h0002, 3, 0, 0, 0, 1, 16'hFF00, 16'h0001, 16'h0000);
        vecs[16] = mk(1, OP_PUSH,    16'h0004, 0, 16'h0004, 16'h0003, 4, 0, 0, 0, 1, 16'hFF01, 16'h0002, 16'h0000);
        vecs[17] = mk(1, OP_BINOP,   16'h0007, 0, 16'h0007, 16'h0002, 3, 0, 0, 2, 0, 16'h0000, 16'h0000, 16'hFF01);
        vecs[18] = mk(1, OP_POP,     16'h0000, 0, 16'h0002, 16'h0001, 2, 0, 0, 2, 0, 16'h0000, 16'h0000, 16'hFF00);
        vecs[19] = mk(1, OP_PUSH,    16'h000A, 0, 16'h000A, 16'h0002, 3, 0, 0, 0, 1, 16'hFF00, 16'h0001, 16'h0000);
        vecs[20] = mk(1, OP_POP,     16'h0000, 0, 16'h0002, 16'h0001, 2, 0, 0, 2, 0, 16'h0000, 16'h0000, 16'hFF00);
        vecs[21] = mk(1, OP_BINOP,   16'h00BB, 0, 16'h00BB, 16'h0000, 1, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);

        for (int i = 0; i < NVEC; i++) begin
            w0 = we_total;
            apply_stimulus(vecs[i].valid, vecs[i].op, vecs[i].data, vecs[i].clr, busy);
            check_output($sformatf("v%0d tos", i),       32'(tos),          32'(vecs[i].tos));
            check_output($sformatf("v%0d nos", i),       32'(nos),          32'(vecs[i].nos));
            check_output($sformatf("v%0d depth", i),     32'(depth),        32'(vecs[i].depth));
            check_output($sformatf("v%0d overflow", i),  32'(overflow),     32'(vecs[i].ovf));
            check_output($sformatf("v%0d underflow", i), 32'(underflow),    32'(vecs[i].unf));
            check_output($sformatf("v%0d busy", i),      32'(busy),         32'(vecs[i].busy));
            check_output($sformatf("v%0d writes", i),    32'(we_total - w0), 32'(vecs[i].we));
            if (vecs[i].we > 0) begin
                check_output($sformatf("v%0d waddr", i), 32'(last_waddr), 32'(vecs[i].waddr));
                check_output($sformatf("v%0d wdata", i), 32'(last_wdata), 32'(vecs[i].wdata));
            end
            if (vecs[i].busy > 0)
                check_output($sformatf("v%0d raddr", i), 32'(mem_read_addr), 32'(vecs[i].raddr));
        end

        // Fill to the limit; slot k ends up holding 16'h1000+k.
        do_reset();
        for (int i = 0; i < 256; i++)
            apply_stimulus(1'b1, OP_PUSH, 16'h1000 + 16'(i), 1'b0, busy);
        check_output("full depth", 32'(depth), 32'd256);
        check_output("full tos",   32'(tos),   32'h10FF);
        check_output("full nos",   32'(nos),   32'h10FE);

        w0 = we_total;
        apply_stimulus(1'b1, OP_PUSH, 16'hBEEF, 1'b0, busy);
        check_output("ovf flag",   32'(overflow),       32'h1);
        check_output("ovf depth",  32'(depth),          32'd256);
        check_output("ovf tos",    32'(tos),            32'h10FF);
        check_output("ovf writes", 32'(we_total - w0),  32'd0);

        apply_stimulus(1'b0, OP_PUSH, 16'h0000, 1'b1, busy);
        check_output("ovf cleared", 32'(overflow), 32'h0);

        apply_stimulus(1'b1, OP_POP, 16'h0000, 1'b0, busy);
        check_output("deep pop tos",   32'(tos),           32'h10FE);
        check_output("deep pop nos",   32'(nos),           32'h10FD);
        check_output("deep pop depth", 32'(depth),         32'd255);
        check_output("deep pop raddr", 32'(mem_read_addr), 32'hFFFD);

        // Reset lands while the refill is in RD1; the fetched word must be dropped.
        cmd_valid = 1'b1;
        cmd_op    = OP_POP;
        @(posedge clock);
        #1 cmd_valid = 1'b0;
        check_output("rd1 busy", 32'(cmd_ready), 32'h0);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        check_output("abort depth", 32'(depth),     32'd0);
        check_output("abort tos",   32'(tos),       32'h0);
        check_output("abort nos",   32'(nos),       32'h0);
        check_output("abort ready", 32'(cmd_ready), 32'h1);
        repeat (3) @(negedge clock);
        #1;
        check_output("abort late nos",   32'(nos),       32'h0);
        check_output("abort late ready", 32'(cmd_ready), 32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
